// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, LSB first, with runtime-selectable
// baud divisor, parity and stop-bit count. Each frame uses the configuration
// that was present when its word left the FIFO.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | line high, waiting for a word in the FIFO
//   S_START  | start bit (low) for one bit time
//   S_DATA   | DATA_W data bits, LSB first
//   S_PARITY | optional parity bit (odd/even)
//   S_STOP   | one or two stop bits (high); may chain into the next frame
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic [1:0]                    par_mode_i,
   input  logic                          stop2_i,
   input  logic [DATA_W-1:0]             din_i,
   input  logic                          din_vld_i,
   output logic                          din_rdy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          tx_dout_o,
   output logic                          tx_busy_o
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int LW    = AW + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [LW-1:0]    FULL     = LW'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q, level_d;
   logic              push, pop, fifo_nempty;
   logic [DATA_W-1:0] head;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_en_q, par_en_d;
   logic              par_bit_q, par_bit_d;
   logic              stop2_q, stop2_d;
   logic              tx_q, tx_d;
   logic              bit_end, load;
   logic [DIV_W-1:0]  div_eff;

   assign din_rdy_o    = (level_q != FULL);
   assign push         = din_vld_i & din_rdy_o;
   assign pop          = load;
   assign fifo_nempty  = (level_q != '0);
   assign head         = mem_q[rd_ptr_q];
   assign div_eff      = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;

   assign fifo_level_o = level_q;
   assign tx_dout_o    = tx_q;
   assign tx_busy_o    = (state_q != S_IDLE) | fifo_nempty;

   // FIFO storage; contents need no reset because level gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Occupancy follows push/pop; simultaneous push and pop cancel out
   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // FIFO pointers and level; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Next-state, bit timing and registered line value for the frame FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      tx_d      = tx_q;
      load      = 1'b0;
      bit_end   = (cnt_q == div_q - DIV_W'(1));

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            load = fifo_nempty;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == LAST_BIT) begin
                  bit_d = '0;
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (stop2_q && (bit_q == '0)) begin
                  bit_d = BIT_W'(1);
                  tx_d  = 1'b1;
               end else if (fifo_nempty) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Popping a word snapshots the configuration for the whole frame
      if (load) begin
         state_d   = S_START;
         cnt_d     = '0;
         bit_d     = '0;
         shreg_d   = head;
         div_d     = div_eff;
         par_en_d  = (par_mode_i == 2'd1) || (par_mode_i == 2'd2);
         par_bit_d = (par_mode_i == 2'd1) ? ~^head : ^head;
         stop2_d   = stop2_i;
         tx_d      = 1'b0;
      end
   end

   // FSM and datapath registers; reset aborts any frame and drives the line high
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= DIV_W'(2);
         bit_q     <= '0;
         shreg_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         tx_q      <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a frame-level reference model predicts the
// line, level, ready and busy after every clock edge; a DATA_W=5 instance
// gets a short directed frame.
module tb_uart_tx_fifo;

   localparam int W     = 8;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic [1:0]  par_mode;
   logic        stop2;
   logic [W-1:0] din;
   logic        din_vld;
   logic        din_rdy;
   logic [4:0]  fifo_level;
   logic        tx_dout;
   logic        tx_busy;

   logic        rst5;
   logic [15:0] baud_div5;
   logic [4:0]  din5;
   logic        din_vld5;
   logic        din_rdy5;
   logic [4:0]  fifo_level5;
   logic        tx_dout5;
   logic        tx_busy5;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .par_mode_i(par_mode),
      .stop2_i(stop2), .din_i(din), .din_vld_i(din_vld), .din_rdy_o(din_rdy),
      .fifo_level_o(fifo_level), .tx_dout_o(tx_dout), .tx_busy_o(tx_busy)
   );

   uart_tx_fifo #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
      .clk_i(clk), .rst_i(rst5), .baud_div_i(baud_div5), .par_mode_i(2'd0),
      .stop2_i(1'b0), .din_i(din5), .din_vld_i(din_vld5), .din_rdy_o(din_rdy5),
      .fifo_level_o(fifo_level5), .tx_dout_o(tx_dout5), .tx_busy_o(tx_busy5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model (frame as a list of line bits) ----------
   logic [W-1:0] q[$];
   bit   m_ok  = 0;
   bit   m_act = 0;
   int   m_pos, m_div, m_len, m_sz;
   bit   m_bits[16];
   bit   m_start, m_push, e_tx;
   logic [W-1:0] m_w;

   always @(posedge clk) begin
      m_sz   = q.size();
      m_push = din_vld && (m_sz != DEPTH);
      if (rst) begin
         q.delete();
         m_act = 0;
         m_ok  = 1;
      end else begin
         m_start = 0;
         if (m_act) begin
            m_pos++;
            if (m_pos == m_len * m_div) begin
               m_act   = 0;
               m_start = (m_sz != 0);
            end
         end else begin
            m_start = (m_sz != 0);
         end
         if (m_start) begin
            m_w = q.pop_front();
            m_bits[0] = 1'b0;
            for (int i = 0; i < W; i++) m_bits[1+i] = m_w[i];
            m_len = 1 + W;
            if (par_mode == 2'd1) begin m_bits[m_len] = ~^m_w; m_len++; end
            if (par_mode == 2'd2) begin m_bits[m_len] = ^m_w;  m_len++; end
            m_bits[m_len] = 1'b1; m_len++;
            if (stop2) begin m_bits[m_len] = 1'b1; m_len++; end
            m_div = (baud_div < 2) ? 2 : int'(baud_div);
            m_pos = 0;
            m_act = 1;
         end
         if (m_push) q.push_back(din);
      end
      e_tx = m_act ? m_bits[m_pos / m_div] : 1'b1;
      #1;
      if (m_ok) begin
         chk("tx_dout",    tx_dout,    e_tx);
         chk("fifo_level", fifo_level, q.size());
         chk("din_rdy",    din_rdy,    q.size() != DEPTH);
         chk("tx_busy",    tx_busy,    m_act || (q.size() != 0));
      end
   end

   // ---------------- stimulus helpers (drive on falling edge) ----------------
   task automatic push_word(input logic [W-1:0] w);
      int n;
      din     = w;
      din_vld = 1'b1;
      n = 0;
      while (!din_rdy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("push_timeout", n < 3000, 1);
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      din_vld = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      din_vld = 1'b0;
      n = 0;
      while ((m_act || q.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", n < 5000, 1);
      @(negedge clk);
   endtask

   task automatic set_cfg(input logic [15:0] d, input logic [1:0] p, input logic s);
      baud_div = d;
      par_mode = p;
      stop2    = s;
   endtask

   task automatic run5(input logic [15:0] bd);
      logic [6:0] pat;
      pat = 7'b1111110;
      @(negedge clk);
      baud_div5 = bd;
      din5      = 5'h1F;
      din_vld5  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_vld5 = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk);
         #1 chk("w5_bit", tx_dout5, pat[k/2]);
      end
      @(posedge clk);
      #1;
      chk("w5_idle_tx", tx_dout5, 1);
      chk("w5_idle_busy", tx_busy5, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1; rst5 = 1'b1;
      din_vld = 1'b0; din = '0;
      din_vld5 = 1'b0; din5 = '0; baud_div5 = 16'd0;
      set_cfg(16'd4, 2'd0, 1'b0);
      repeat (3) @(negedge clk);
      rst5 = 1'b0;
      #1;
      chk("w5_rst_tx", tx_dout5, 1);
      chk("w5_rst_lvl", fifo_level5, 0);
      chk("w5_rst_rdy", din_rdy5, 1);
      run5(16'd0);
      run5(16'd1);
      rst = 1'b0;
      @(negedge clk);

      // 8N1, div 4, single 0x55
      push_word(8'h55);
      wait_idle();

      // parity cases at div 2
      set_cfg(16'd2, 2'd2, 1'b0); push_word(8'h03); wait_idle();
      set_cfg(16'd2, 2'd1, 1'b0); push_word(8'h03); wait_idle();
      set_cfg(16'd2, 2'd1, 1'b0); push_word(8'h00); wait_idle();

      // backpressure: 17 back-to-back words at div 4
      set_cfg(16'd4, 2'd0, 1'b0);
      for (int i = 0; i < 17; i++) push_word(W'($urandom));
      wait_idle();

      // two stop bits at div 3, config changed mid-frame
      set_cfg(16'd3, 2'd0, 1'b1);
      push_word(8'hA5);
      push_word(8'h3C);
      idle_cycles(15);
      set_cfg(16'd5, 2'd2, 1'b0);
      wait_idle();

      // divisor edge values
      set_cfg(16'd0, 2'd0, 1'b0); push_word(8'h96); wait_idle();
      set_cfg(16'd1, 2'd1, 1'b1); push_word(8'h69); wait_idle();

      // reset during DATA of the second of three queued words
      set_cfg(16'd4, 2'd0, 1'b0);
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      idle_cycles(55);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(100);

      // randomized traffic and configuration
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0)
            set_cfg(16'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         push_word(W'($urandom));
         if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 30));
      end
      wait_idle();
      idle_cycles(5);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
